// File: rtl/uart_rx_pkg.sv
// Shared definitions for the 8N1 UART receiver: FSM state encoding and
// oversampling constants.
package uart_rx_pkg;

    localparam int         OVERSAMPLE = 16;
    localparam logic [3:0] MID_IDX    = 4'd7;
    localparam logic [3:0] END_IDX    = 4'd15;
    localparam int         FRAME_BITS = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

endpackage

// File: rtl/uart_rx_tick.sv
// Free-running divider producing one-clk sample ticks at OVERSAMPLE x baud.
module uart_rx_tick #(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling, mid-bit start validation, centre-sampled
// data/stop bits, valid/ack byte handshake with framing-error and overrun pulses.
module uart_rx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rx_ack,
    output logic [7:0] rxdata,
    output logic       rx_valid,
    output logic       framing_err,
    output logic       overrun,
    output logic       busy
);

    import uart_rx_pkg::*;

    localparam int         DIV      = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 1);

    logic rx_meta;
    logic rs;
    logic tick;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rs      <= 1'b1;
        end else begin
            rx_meta <= rx;
            rs      <= rx_meta;
        end
    end

    uart_rx_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    state_t     state, state_n;
    logic [3:0] scnt, scnt_n;
    logic [2:0] bidx, bidx_n;
    logic [7:0] shreg, shreg_n;
    logic       load;
    logic       ferr;

    always_comb begin
        // NOTE: every variable gets a default first so no latch can be inferred.
        state_n = state;
        scnt_n  = scnt;
        bidx_n  = bidx;
        shreg_n = shreg;
        load    = 1'b0;
        ferr    = 1'b0;
        case (state)
            IDLE: begin
                scnt_n = 4'd0;
                if (tick && !rs)
                    state_n = START;
            end
            START: if (tick) begin
                if (scnt == MID_IDX) begin
                    scnt_n  = 4'd0;
                    bidx_n  = 3'd0;
                    state_n = rs ? IDLE : DATA;
                end else begin
                    scnt_n = scnt + 4'd1;
                end
            end
            DATA: if (tick) begin
                scnt_n = scnt + 4'd1;
                if (scnt == END_IDX) begin
                    shreg_n = {rs, shreg[7:1]};
                    bidx_n  = bidx + 3'd1;
                    if (bidx == LAST_BIT)
                        state_n = STOP;
                end
            end
            STOP: if (tick) begin
                scnt_n = scnt + 4'd1;
                if (scnt == END_IDX) begin
                    if (rs) begin
                        load    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr    = 1'b1;
                        state_n = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                scnt_n = 4'd0;
                if (tick && rs)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            scnt        <= 4'd0;
            bidx        <= 3'd0;
            shreg       <= 8'h00;
            rxdata      <= 8'h00;
            rx_valid    <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            scnt        <= scnt_n;
            bidx        <= bidx_n;
            shreg       <= shreg_n;
            framing_err <= ferr;
            overrun     <= load && rx_valid && !rx_ack;
            busy        <= (state_n != IDLE);
            // A completing byte wins over a same-cycle ack: valid stays set.
            if (load) begin
                rxdata   <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames scored
// against a transaction-level model of the receiver's byte/handshake behaviour.
module tb_uart_rx;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 25_000;
    localparam int OVS      = 16;
    localparam int DIV      = CLK_FREQ / (BAUD * OVS);
    localparam int BIT_CLK  = DIV * OVS;
    // Frames start so that the start bit is first seen on a tick two clocks
    // after the line falls; the stop-bit centre is then 152 ticks later.
    localparam int DONE_NEG = 2 + 152 * DIV;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       rx_ack;
    logic [7:0] rxdata;
    logic       rx_valid;
    logic       framing_err;
    logic       overrun;
    logic       busy;

    uart_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .rx_ack      (rx_ack),
        .rxdata      (rxdata),
        .rx_valid    (rx_valid),
        .framing_err (framing_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what the consumer should see.
    logic [7:0] m_data  = 8'h00;
    bit         m_valid = 1'b0;
    int         m_ferr  = 0;
    int         m_ovr   = 0;

    int ferr_seen = 0;
    int ovr_seen  = 0;
    int since_rst = 0;

    always @(negedge clk) begin
        if (framing_err === 1'b1) ferr_seen++;
        if (overrun === 1'b1)     ovr_seen++;
    end

    always @(posedge clk) begin
        if (rst) since_rst <= 0;
        else     since_rst <= since_rst + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Stop at the negedge after which the next-but-one posedge is a sample tick.
    task automatic align();
        @(negedge clk);
        while ((since_rst % DIV) != DIV - 3) @(negedge clk);
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        m_valid = 1'b0;
        check("ack_clears_valid", rx_valid, 1'b0);
        check("ack_keeps_data", rxdata, m_data);
    endtask

    task automatic send_frame(input logic [7:0] data, input bit stop_ok,
                              input bit ack_sim, input int extra_low);
        bit exp_ovr;
        align();
        fork
            begin
                rx = 1'b0;
                repeat (BIT_CLK) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    rx = data[i];
                    repeat (BIT_CLK) @(negedge clk);
                end
                rx = stop_ok;
                repeat (BIT_CLK) @(negedge clk);
                if (!stop_ok && extra_low > 0) begin
                    repeat (extra_low * BIT_CLK) @(negedge clk);
                    check("busy_in_break", busy, 1'b1);
                end
                rx = 1'b1;
            end
            begin
                repeat (DONE_NEG) @(negedge clk);
                check("busy_at_stop", busy, 1'b1);
                check("data_before_stop", rxdata, m_data);
                check("valid_before_stop", rx_valid, m_valid);
                rx_ack = ack_sim;
                @(negedge clk);
                rx_ack = 1'b0;
                exp_ovr = stop_ok && m_valid && !ack_sim;
                if (stop_ok) begin
                    m_data  = data;
                    m_valid = 1'b1;
                    if (exp_ovr) m_ovr++;
                end else begin
                    m_ferr++;
                end
                check("rxdata", rxdata, m_data);
                check("rx_valid", rx_valid, m_valid);
                check("framing_err", framing_err, !stop_ok);
                check("overrun", overrun, exp_ovr);
                @(negedge clk);
                check("ferr_one_clk", framing_err, 1'b0);
                check("ovr_one_clk", overrun, 1'b0);
            end
        join
        repeat (BIT_CLK / 2) @(negedge clk);
        check("busy_idle", busy, 1'b0);
        check("valid_held", rx_valid, m_valid);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        rx     = 1'b1;
        rx_ack = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_rxdata", rxdata, 8'h00);
        check("rst_valid", rx_valid, 1'b0);
        check("rst_ferr", framing_err, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (BIT_CLK) @(negedge clk);

        // Clean frame, no ack: byte held.
        send_frame(8'hA5, 1'b1, 1'b0, 0);

        // Three-tick glitch: rejected at mid start bit.
        align();
        rx = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        check("glitch_busy", busy, 1'b1);
        rx = 1'b1;
        repeat (2 + 8 * DIV - 3 * DIV) @(negedge clk);
        check("glitch_busy_pre_mid", busy, 1'b1);
        @(negedge clk);
        check("glitch_busy_mid", busy, 1'b0);
        repeat (BIT_CLK) @(negedge clk);
        check("glitch_valid", rx_valid, m_valid);
        check("glitch_data", rxdata, m_data);
        check("glitch_ferr", ferr_seen, m_ferr);

        // Ack clears valid; ack on an empty receiver is ignored.
        ack_pulse();
        ack_pulse();

        // Framing error followed by a two-bit break.
        send_frame(8'h3C, 1'b0, 1'b0, 2);

        // Back-to-back without ack -> overrun; then simultaneous ack -> none.
        send_frame(8'h11, 1'b1, 1'b0, 0);
        send_frame(8'h22, 1'b1, 1'b0, 0);
        send_frame(8'h44, 1'b1, 1'b1, 0);

        // Reset after four data bits of 0xFF.
        align();
        rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        rx = 1'b1;
        repeat (4 * BIT_CLK) @(negedge clk);
        check("busy_mid_frame", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_data  = 8'h00;
        m_valid = 1'b0;
        check("mid_rst_rxdata", rxdata, 8'h00);
        check("mid_rst_valid", rx_valid, 1'b0);
        check("mid_rst_ferr", framing_err, 1'b0);
        check("mid_rst_ovr", overrun, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        repeat (BIT_CLK) @(negedge clk);
        send_frame(8'h7E, 1'b1, 1'b0, 0);
        ack_pulse();

        // Loopback-style traffic, acked after each byte.
        send_frame(8'h00, 1'b1, 1'b0, 0);
        ack_pulse();
        send_frame(8'hFF, 1'b1, 1'b0, 0);
        ack_pulse();
        send_frame(8'h55, 1'b1, 1'b0, 0);
        ack_pulse();

        // Random frames: random data, occasional bad stop bit, random ack style.
        for (int n = 0; n < 12; n++) begin
            logic [7:0] d;
            int         mode;
            bit         ok;
            d    = 8'($urandom_range(0, 255));
            mode = int'($urandom_range(0, 2));
            ok   = ($urandom_range(0, 5) != 0);
            send_frame(d, ok, mode == 1, 0);
            if (mode == 2) ack_pulse();
        end

        check("ferr_total", ferr_seen, m_ferr);
        check("ovr_total", ovr_seen, m_ovr);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
